// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with programmable almost-full/empty thresholds, sticky error flags and occupancy count.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is a registered read port.
module sync_fifo_flags #(
    parameter int unsigned FIFO_WIDTH    = 14,
    parameter int unsigned FIFO_DEPTH    = 64,
    parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 4,
    parameter int unsigned AEMPTY_THRESH = 4,
    localparam int unsigned CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almst_full,
    output logic                  fifo_almst_empty,
    output logic [CW-1:0]         fifo_count,
    input  logic                  err_clr,
    output logic                  fifo_ovf,
    output logic                  fifo_udf
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_ovf_evt;
    logic                  w_udf_evt;
    logic [CW-1:0]         w_count_next;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a write alongside a read.
    always_comb begin
        w_rd_acc     = rd_en & ~r_empty;
        w_wr_acc     = wr_en & (~r_full | w_rd_acc);
        w_ovf_evt    = wr_en & ~w_wr_acc;
        w_udf_evt    = rd_en & r_empty;
        w_count_next = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer, count and flag state; flags are decoded from the next count so they track the access edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count  <= w_count_next;
            r_full   <= (w_count_next == CW'(FIFO_DEPTH));
            r_empty  <= (w_count_next == '0);
            r_afull  <= (w_count_next >= CW'(AFULL_THRESH));
            r_aempty <= (w_count_next <= CW'(AEMPTY_THRESH));
        end
    end

    // Sticky errors: a fresh error takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_udf_evt) begin
                r_udf <= 1'b1;
            end else if (err_clr) begin
                r_udf <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry is presented directly; forced to zero while empty so reset leaves rd_data cleared.
    assign rd_data  = r_empty ? '0 : r_mem[r_rd_ptr];
    assign rd_valid = ~r_empty;
`else
    logic [FIFO_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`endif

    assign fifo_full        = r_full;
    assign fifo_empty       = r_empty;
    assign fifo_almst_full  = r_afull;
    assign fifo_almst_empty = r_aempty;
    assign fifo_count       = r_count;
    assign fifo_ovf         = r_ovf;
    assign fifo_udf         = r_udf;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_sync_fifo_flags;

    localparam int unsigned W      = 14;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AFULL  = 12;
    localparam int unsigned AEMPTY = 4;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [W-1:0]  wr_data;
    logic          rd_en;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_almst_full;
    logic          fifo_almst_empty;
    logic [CW-1:0] fifo_count;
    logic          err_clr;
    logic          fifo_ovf;
    logic          fifo_udf;

    sync_fifo_flags #(
        .FIFO_WIDTH   (W),
        .FIFO_DEPTH   (DEPTH),
        .AFULL_THRESH (AFULL),
        .AEMPTY_THRESH(AEMPTY)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .fifo_almst_full (fifo_almst_full),
        .fifo_almst_empty(fifo_almst_empty),
        .fifo_count      (fifo_count),
        .err_clr         (err_clr),
        .fifo_ovf        (fifo_ovf),
        .fifo_udf        (fifo_udf)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [W-1:0] mq[$];
    logic [W-1:0] e_rd_data;
    logic         e_rd_valid;
    logic         e_ovf;
    logic         e_udf;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        e_rd_data  = '0;
        e_rd_valid = 1'b0;
        e_ovf      = 1'b0;
        e_udf      = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = mq.size();
`ifdef FIFO_FWFT_EN
        e_rd_data  = (sz > 0) ? mq[0] : '0;
        e_rd_valid = (sz > 0);
`endif
        chk({tag, ":count"},  32'(fifo_count),       32'(sz));
        chk({tag, ":full"},   32'(fifo_full),        32'(sz == DEPTH));
        chk({tag, ":empty"},  32'(fifo_empty),       32'(sz == 0));
        chk({tag, ":afull"},  32'(fifo_almst_full),  32'(sz >= AFULL));
        chk({tag, ":aempty"}, 32'(fifo_almst_empty), 32'(sz <= AEMPTY));
        chk({tag, ":ovf"},    32'(fifo_ovf),         32'(e_ovf));
        chk({tag, ":udf"},    32'(fifo_udf),         32'(e_udf));
        chk({tag, ":rvalid"}, 32'(rd_valid),         32'(e_rd_valid));
        chk({tag, ":rdata"},  32'(rd_data),          32'(e_rd_data));
    endtask

    // One clock of traffic; the model applies the acceptance rules to its pre-edge occupancy.
    task automatic step(input logic wr, input logic rd, input logic clr, input logic [W-1:0] d,
                        input string tag);
        int sz;
        bit racc;
        bit wacc;
        wr_en   = wr;
        rd_en   = rd;
        err_clr = clr;
        wr_data = d;
        sz   = mq.size();
        racc = rd && (sz > 0);
        wacc = wr && ((sz < DEPTH) || racc);
        @(posedge clk);
        #1;
        if (racc) begin
            e_rd_data  = mq.pop_front();
            e_rd_valid = 1'b1;
        end else begin
            e_rd_valid = 1'b0;
        end
        if (wacc) mq.push_back(d);
        if (wr && !wacc) e_ovf = 1'b1;
        else if (clr)    e_ovf = 1'b0;
        if (rd && sz == 0) e_udf = 1'b1;
        else if (clr)      e_udf = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        err_clr = 1'b0;
        #2;
        model_reset();
        check_all({tag, ":async"});
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all({tag, ":held"});
        rst_n = 1'b1;
    endtask

    int phase_wr;
    int phase_rd;

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        wr_data = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset("init");

        // Fill to full, one extra write, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0, W'(i), "fill");
`ifdef FIFO_FWFT_EN
            if (i == 0) chk("fwft_first", 32'(rd_data), 32'd0);
`endif
            if (i == AFULL - 2) chk("afull_below", 32'(fifo_almst_full), 32'd0);
            if (i == AFULL - 1) chk("afull_at",    32'(fifo_almst_full), 32'd1);
        end
        chk("full_at_depth", 32'(fifo_full), 32'd1);
        step(1'b1, 1'b0, 1'b0, W'(14'h3abc), "extra_wr");
        chk("ovf_set", 32'(fifo_ovf), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0, '0, "drain");
`ifndef FIFO_FWFT_EN
            chk("drain_order", 32'(rd_data), 32'(i));
`endif
        end
        chk("empty_after_drain", 32'(fifo_empty), 32'd1);

        // Read on empty, then clear errors
        step(1'b0, 1'b1, 1'b0, '0, "udf_rd");
        chk("udf_set", 32'(fifo_udf), 32'd1);
        chk("udf_rvalid", 32'(rd_valid), 32'd0);
        step(1'b0, 1'b0, 1'b1, '0, "err_clr");
        chk("udf_cleared", 32'(fifo_udf), 32'd0);

        // Empty with simultaneous read and write
        step(1'b1, 1'b1, 1'b0, W'(14'h0123), "empty_rw");
        chk("empty_rw_count", 32'(fifo_count), 32'd1);
        step(1'b0, 1'b1, 1'b1, '0, "empty_rw_pop");

        // Full with simultaneous read and write for 5 cycles
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, W'(100 + i), "refill");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, W'(200 + i), "full_rw");
            chk("full_rw_count", 32'(fifo_count), 32'(DEPTH));
        end
        chk("full_rw_no_ovf", 32'(fifo_ovf), 32'd0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0, "full_rw_drain");

        // Pointer wrap
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, W'(300 + i), "wrap_w10");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, '0, "wrap_r10");
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0, W'(400 + i), "wrap_w15");
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, '0, "wrap_r15");

        // Randomized traffic with shifting read/write bias and one mid-traffic reset
        phase_wr = 50;
        phase_rd = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                phase_wr = int'($urandom_range(90, 10));
                phase_rd = int'($urandom_range(90, 10));
            end
            if (c == 1500) do_reset("mid_reset");
            step(($urandom % 100) < phase_wr, ($urandom % 100) < phase_rd,
                 ($urandom % 16) == 0, W'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
